// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster for the complete stage.
// Buffers one finished result per functional unit in a holding slot and broadcasts one
// slot per cycle on the registered CDB, along with a one-hot fu_free release pulse.
// Arbitration is round-robin by default; defining CDB_FIXED_PRIO_EN switches it to a
// fixed lowest-index-wins priority with no rotating pointer.
module cdb_broadcaster #(
  parameter int unsigned NUM_FU = 5,
  parameter int unsigned PREG_W = 9,
  parameter int unsigned ROB_W  = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*PREG_W-1:0]   fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data,
  input  logic [NUM_FU*ROB_W-1:0]    fu_rob_idx,
  output logic [NUM_FU-1:0]          fu_ready,
  output logic                       cdb_valid,
  output logic [PREG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [ROB_W-1:0]           cdb_rob_idx,
  output logic [NUM_FU-1:0]          fu_free
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] hold_valid_q;
  logic [PREG_W-1:0] hold_tag_q  [NUM_FU];
  logic [DATA_W-1:0] hold_data_q [NUM_FU];
  logic [ROB_W-1:0]  hold_rob_q  [NUM_FU];

  logic [NUM_FU-1:0] grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;

`ifdef CDB_FIXED_PRIO_EN
  // Lowest-index pending slot wins; starvation of higher indices is accepted.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (!grant_any && hold_valid_q[k]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(k);
        grant[k]  = 1'b1;
      end
    end
  end
`else
  localparam logic [PTR_W:0] NumFuExt = (PTR_W+1)'(NUM_FU);

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W:0]   scan_sum;
  logic [PTR_W-1:0] scan_idx;

  // Scan slots starting at rr_ptr, wrapping modulo NUM_FU; first pending slot wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_sum >= NumFuExt) begin
        scan_sum = scan_sum - NumFuExt;
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!grant_any && hold_valid_q[scan_idx]) begin
        grant_any        = 1'b1;
        grant_idx        = scan_idx;
        grant[scan_idx]  = 1'b1;
      end
    end
  end

  // Pointer moves just past the granted slot; flush leaves it untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (!flush && grant_any) begin
      if (grant_idx == PTR_W'(NUM_FU - 1)) begin
        rr_ptr_q <= '0;
      end else begin
        rr_ptr_q <= grant_idx + PTR_W'(1);
      end
    end
  end
`endif

  // A slot draining this cycle can be refilled in the same edge; flush accepts-and-drops.
  assign fu_ready = flush ? '1 : (~hold_valid_q | grant);

  // Holding slots: capture on valid/ready handshake, release when broadcast.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid_q <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        hold_tag_q[i]  <= '0;
        hold_data_q[i] <= '0;
        hold_rob_q[i]  <= '0;
      end
    end else if (flush) begin
      hold_valid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          hold_valid_q[i] <= 1'b1;
          hold_tag_q[i]   <= fu_tag[i*PREG_W +: PREG_W];
          hold_data_q[i]  <= fu_data[i*DATA_W +: DATA_W];
          hold_rob_q[i]   <= fu_rob_idx[i*ROB_W +: ROB_W];
        end else if (grant[i]) begin
          hold_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Registered CDB; payload holds its last value when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid   <= 1'b0;
      cdb_tag     <= '0;
      cdb_data    <= '0;
      cdb_rob_idx <= '0;
      fu_free     <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
      fu_free   <= '0;
    end else if (grant_any) begin
      cdb_valid   <= 1'b1;
      cdb_tag     <= hold_tag_q[grant_idx];
      cdb_data    <= hold_data_q[grant_idx];
      cdb_rob_idx <= hold_rob_q[grant_idx];
      fu_free     <= grant;
    end else begin
      cdb_valid <= 1'b0;
      fu_free   <= '0;
    end
  end

endmodule
